fetch_queue: RTL and testbench

//  Instruction buffer between the fetch stage and decode. Captures each completed

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fq_storage.sv | 33 +++
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry layout for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

    localparam int          WORD_W   = 16;
    localparam logic [15:0] NOP_INST = 16'h0800;
    localparam int          ENTRY_W  = 2 * WORD_W + 1;

    typedef struct packed {
        logic [WORD_W-1:0] inst;
        logic [WORD_W-1:0] pcplus2;
        logic              err;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Entry storage for the fetch queue: one synchronous write port, one async read port.
// Contents are don't-care after reset, so the array carries no reset.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode; presents the oldest entry or a NOP,
// and is emptied by a resolved taken branch/jump.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [15:0] if_inst,
    input  logic [15:0] if_pcplus2,
    input  logic        if_err,
    input  logic        flush,
    input  logic        id_ready,
    output logic        fq_stall,
    output logic        id_valid,
    output logic [15:0] id_inst,
    output logic [15:0] id_pcplus2,
    output logic        id_err,
    output logic        ovf_err
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_err_q, ovf_err_d;

    logic          full;
    logic          pop;
    logic          push;
    fq_entry_t     wr_entry;
    fq_entry_t     rd_entry;
    logic [ENTRY_W-1:0] rd_raw;

    assign full     = (count_q == FULL_CNT);
    assign id_valid = (count_q != '0);
    assign pop      = id_valid & id_ready & ~flush;
    // A pop frees the slot in the same cycle, so a full queue can still accept.
    assign push     = if_valid & ~flush & (~full | pop);

    assign wr_entry = '{inst: if_inst, pcplus2: if_pcplus2, err: if_err};

    fq_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_raw)
    );

    assign rd_entry = rd_raw;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        ovf_err_d = ovf_err_q | (if_valid & ~flush & full & ~pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    assign fq_stall   = full;
    assign ovf_err    = ovf_err_q;
    assign id_inst    = id_valid ? rd_entry.inst    : NOP_INST;
    assign id_pcplus2 = id_valid ? rd_entry.pcplus2 : 16'h0000;
    assign id_err     = id_valid ? rd_entry.err     : 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: reset, single pass-through, fill and
// overflow, full push+pop, flush, and asynchronous reset mid-stream.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_inst;
    logic [15:0] if_pcplus2;
    logic        if_err;
    logic        flush;
    logic        id_ready;
    logic        fq_stall;
    logic        id_valid;
    logic [15:0] id_inst;
    logic [15:0] id_pcplus2;
    logic        id_err;
    logic        ovf_err;

    int n_checks = 0;
    int n_errors = 0;

    fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pcplus2 (if_pcplus2),
        .if_err     (if_err),
        .flush      (flush),
        .id_ready   (id_ready),
        .fq_stall   (fq_stall),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pcplus2 (id_pcplus2),
        .id_err     (id_err),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc,
                         input logic err, input logic rdy, input logic fl);
        if_valid   = v;
        if_inst    = inst;
        if_pcplus2 = pc;
        if_err     = err;
        id_ready   = rdy;
        flush      = fl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({id_valid, id_inst, id_pcplus2, id_err, fq_stall, ovf_err} !== {1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b inst=%h pc=%h err=%b stall=%b ovf=%b, expected 0 0800 0000 0 0 0",
                     id_valid, id_inst, id_pcplus2, id_err, fq_stall, ovf_err);
        end
        step();
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if ({id_valid, id_inst, fq_stall, ovf_err} !== {1'b0, 16'h0800, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL idle_after_reset: got v=%b inst=%h stall=%b ovf=%b, expected 0 0800 0 0",
                     id_valid, id_inst, fq_stall, ovf_err);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 16'hC123, 16'h0002, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (id_valid !== 1'b0 || id_inst !== 16'h0800) begin
            n_errors++;
            $display("FAIL no_bypass: got v=%b inst=%h, expected 0 0800", id_valid, id_inst);
        end
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({id_valid, id_inst, id_pcplus2, id_err} !== {1'b1, 16'hC123, 16'h0002, 1'b0}) begin
            n_errors++;
            $display("FAIL single_head: got v=%b inst=%h pc=%h err=%b, expected 1 c123 0002 0",
                     id_valid, id_inst, id_pcplus2, id_err);
        end
        step();
        n_checks++;
        if ({id_valid, id_inst, id_pcplus2} !== {1'b0, 16'h0800, 16'h0000}) begin
            n_errors++;
            $display("FAIL single_drain: got v=%b inst=%h pc=%h, expected 0 0800 0000",
                     id_valid, id_inst, id_pcplus2);
        end
    endtask

    task automatic test_full_overflow();
        drive(1'b1, 16'h1111, 16'h0010, 1'b0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (fq_stall !== 1'b0 || id_inst !== 16'h1111) begin
            n_errors++;
            $display("FAIL fill_one: got stall=%b inst=%h, expected 0 1111", fq_stall, id_inst);
        end
        drive(1'b1, 16'h2222, 16'h0012, 1'b0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (fq_stall !== 1'b1 || id_inst !== 16'h1111 || ovf_err !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_two: got stall=%b inst=%h ovf=%b, expected 1 1111 0", fq_stall, id_inst, ovf_err);
        end
        drive(1'b1, 16'h5555, 16'h0014, 1'b0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (ovf_err !== 1'b1 || fq_stall !== 1'b1 || id_inst !== 16'h1111) begin
            n_errors++;
            $display("FAIL overflow_drop: got ovf=%b stall=%b inst=%h, expected 1 1 1111", ovf_err, fq_stall, id_inst);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        step();
        n_checks++;
        if (id_inst !== 16'h2222 || id_pcplus2 !== 16'h0012 || fq_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL pop_order_2: got inst=%h pc=%h stall=%b, expected 2222 0012 0", id_inst, id_pcplus2, fq_stall);
        end
        step();
        n_checks++;
        if (id_valid !== 1'b0 || id_inst !== 16'h0800 || ovf_err !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_no_5555: got v=%b inst=%h ovf=%b, expected 0 0800 1", id_valid, id_inst, ovf_err);
        end
    endtask

    task automatic test_full_push_pop();
        drive(1'b1, 16'h1111, 16'h0020, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h2222, 16'h0022, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h3333, 16'h0024, 1'b0, 1'b1, 1'b0);
        step();
        n_checks++;
        if (fq_stall !== 1'b1 || id_inst !== 16'h2222 || id_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL full_push_pop: got stall=%b inst=%h v=%b, expected 1 2222 1", fq_stall, id_inst, id_valid);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        step();
        n_checks++;
        if (id_inst !== 16'h3333 || id_pcplus2 !== 16'h0024 || fq_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL full_push_pop_next: got inst=%h pc=%h stall=%b, expected 3333 0024 0", id_inst, id_pcplus2, fq_stall);
        end
        step();
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL full_push_pop_drain: got v=%b, expected 0", id_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h6666, 16'h0030, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h7777, 16'h0032, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h4444, 16'h0034, 1'b0, 1'b1, 1'b1);
        step();
        n_checks++;
        if ({id_valid, id_inst, fq_stall, ovf_err} !== {1'b0, 16'h0800, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL flush_empty: got v=%b inst=%h stall=%b ovf=%b, expected 0 0800 0 1",
                     id_valid, id_inst, fq_stall, ovf_err);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        step();
        n_checks++;
        if (id_valid !== 1'b0 || id_inst !== 16'h0800) begin
            n_errors++;
            $display("FAIL flush_discard: got v=%b inst=%h, expected 0 0800", id_valid, id_inst);
        end
    endtask

    task automatic test_err_reset();
        drive(1'b1, 16'h8888, 16'h0040, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h9999, 16'h0042, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (id_err !== 1'b1 || id_inst !== 16'h8888) begin
            n_errors++;
            $display("FAIL err_head: got err=%b inst=%h, expected 1 8888", id_err, id_inst);
        end
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({id_valid, id_inst, id_pcplus2, id_err, fq_stall, ovf_err} !== {1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL midstream_reset: got v=%b inst=%h pc=%h err=%b stall=%b ovf=%b, expected 0 0800 0000 0 0 0",
                     id_valid, id_inst, id_pcplus2, id_err, fq_stall, ovf_err);
        end
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (id_valid !== 1'b0 || fq_stall !== 1'b0 || id_inst !== 16'h0800) begin
            n_errors++;
            $display("FAIL post_reset_empty: got v=%b stall=%b inst=%h, expected 0 0 0800", id_valid, fq_stall, id_inst);
        end
        drive(1'b1, 16'hAAAA, 16'h0050, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({id_valid, id_inst, id_pcplus2, id_err} !== {1'b1, 16'hAAAA, 16'h0050, 1'b0}) begin
            n_errors++;
            $display("FAIL post_reset_push: got v=%b inst=%h pc=%h err=%b, expected 1 aaaa 0050 0",
                     id_valid, id_inst, id_pcplus2, id_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_overflow();
        test_full_push_pop();
        test_flush();
        test_err_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
